pipe_stage_skid: RTL and testbench



---
 rtl/mips_pkg.sv | 36 +++
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_stage_skid.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage core's pipeline boundary registers.
//   - Bit positions inside the 11-bit control bundle carried between stages.
//   - State encoding for the pipe_stage_skid occupancy FSM.
//   - Small helpers used by the stage register.
// ---------------------------------------------------------------------------
package mips_pkg;

   // Control bundle layout (LSB first)
   localparam int CTRL_MEMWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_WEN       = 2;
   localparam int CTRL_REGDST    = 3;
   localparam int CTRL_MEMTOREG  = 4;
   localparam int CTRL_ALUSRC    = 5;
   localparam int CTRL_PCCTL     = 6;
   localparam int CTRL_ALUOP_LSB = 7;
   localparam int CTRL_W         = 11;

   // Occupancy of the main (M) / skid (S) register pair
   typedef logic [1:0] pipe_state_t;
   localparam logic [1:0] ST_EMPTY = 2'd0;   // M and S invalid
   localparam logic [1:0] ST_ONE   = 2'd1;   // M valid
   localparam logic [1:0] ST_FULL  = 2'd2;   // M and S valid

   // Number of beats held by the stage in a given state.
   function automatic logic [1:0] st_beats(input pipe_state_t st);
      case (st)
         ST_ONE:  st_beats = 2'd1;
         ST_FULL: st_beats = 2'd2;
         default: st_beats = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Free-running statistics counter that adds 0..3 per cycle and sticks at
// all-ones instead of wrapping.
//   clk    in   clock
//   rst_n  in   asynchronous active-low clear
//   inc    in   [1:0] amount to add this cycle
//   cnt    out  [CNT_W-1:0] current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;

   // One extra bit catches overflow; with inc <= 3 a carry out always means
   // the true sum exceeded all-ones.
   always_comb begin
      sum   = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc};
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// One pipeline boundary of the 5-stage core: valid/ready handshake with a
// 2-entry skid (main M drives the outputs, skid S catches the beat that
// arrives while downstream stalls). in_ready is registered so upstream never
// sees a combinational path from out_ready.
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat (registered)
//   in_data    in   [DATA_W-1:0] payload
//   in_ctrl    in   [CTRL_W-1:0] control bundle
//   flush      in   synchronous kill of held and incoming beats
//   out_valid  out  downstream beat valid
//   out_ready  in   downstream can accept
//   out_data   out  [DATA_W-1:0] payload (holds last value on bubbles)
//   out_ctrl   out  [CTRL_W-1:0] control bundle, zero on bubbles
//   stall_cnt  out  [CNT_W-1:0] cycles with out_valid & !out_ready (saturating)
//   drop_cnt   out  [CNT_W-1:0] beats discarded by flush (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 11,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   import mips_pkg::*;

   pipe_state_t       state_q, state_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
   logic              in_ready_q, in_ready_d;

   logic              acc, fire;
   logic [1:0]        stall_inc, drop_inc;
   logic [1:0]        held;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = m_data_q;
   // Bubbles must never carry a write/memory enable downstream.
   assign out_ctrl  = out_valid ? m_ctrl_q : '0;

   always_comb begin
      acc      = in_valid & in_ready_q;
      fire     = out_valid & out_ready;

      state_d  = state_q;
      m_data_d = m_data_q;
      m_ctrl_d = m_ctrl_q;
      s_data_d = s_data_q;
      s_ctrl_d = s_ctrl_q;
      drop_inc = 2'd0;
      held     = st_beats(state_q);

      if (flush) begin
         // A beat leaving through the output this cycle still completes, so
         // it is not counted; an incoming beat counts but is not captured.
         state_d  = ST_EMPTY;
         drop_inc = held - {1'b0, fire} + {1'b0, acc};
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d  = ST_ONE;
                  m_data_d = in_data;
                  m_ctrl_d = in_ctrl;
               end
            end
            ST_ONE: begin
               if (acc && !fire) begin
                  state_d  = ST_FULL;
                  s_data_d = in_data;
                  s_ctrl_d = in_ctrl;
               end else if (acc && fire) begin
                  m_data_d = in_data;
                  m_ctrl_d = in_ctrl;
               end else if (fire) begin
                  state_d  = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only draining is possible.
               if (fire) begin
                  state_d  = ST_ONE;
                  m_data_d = s_data_q;
                  m_ctrl_d = s_ctrl_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      // Registered ready: accept next cycle whenever the skid will be free.
      in_ready_d = (state_d != ST_FULL);
      stall_inc  = {1'b0, out_valid & ~out_ready};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         m_data_q   <= '0;
         m_ctrl_q   <= '0;
         s_data_q   <= '0;
         s_ctrl_q   <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         m_data_q   <= m_data_d;
         m_ctrl_q   <= m_ctrl_d;
         s_data_q   <= s_data_d;
         s_ctrl_q   <= s_ctrl_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc   (stall_inc),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc   (drop_inc),
      .cnt   (drop_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed scenarios plus a randomized run, compared against a queue-based
// model of a 2-deep FIFO stage with saturating counters.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int DW   = 32;
   localparam int CW   = 11;
   localparam int NW   = 4;
   localparam int MAXC = (1 << NW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [NW-1:0] stall_cnt;
   logic [NW-1:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; } beat_t;
   beat_t         q[$];
   int            stall_m = 0;
   int            drop_m  = 0;
   logic [DW-1:0] last_d  = '0;

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   task automatic model_reset();
      q.delete();
      stall_m = 0;
      drop_m  = 0;
      last_d  = '0;
   endtask

   // One clock edge of a 2-deep FIFO: ready means "fewer than 2 held".
   task automatic model_edge(input logic iv, input logic [DW-1:0] d,
                             input logic [CW-1:0] c, input logic ordy, input logic fl);
      int    n;
      int    f;
      int    a;
      beat_t b;
      n = q.size();
      f = (n > 0 && ordy) ? 1 : 0;
      a = (iv && n < 2) ? 1 : 0;
      if (n > 0 && !ordy) stall_m = sat(stall_m + 1);
      if (fl) begin
         drop_m = sat(drop_m + n - f + a);
         q.delete();
      end else begin
         if (f == 1) void'(q.pop_front());
         if (a == 1) begin
            b.d = d;
            b.c = c;
            q.push_back(b);
         end
      end
      if (q.size() > 0) last_d = q[0].d;
   endtask

   function automatic logic [52:0] exp_vec();
      logic [CW-1:0] c;
      logic          v;
      v = (q.size() > 0);
      c = '0;
      if (v) c = q[0].c;
      return {v, logic'(q.size() < 2), last_d, c, NW'(stall_m), NW'(drop_m)};
   endfunction

   function automatic logic [52:0] act_vec();
      return {out_valid, in_ready, out_data, out_ctrl, stall_cnt, drop_cnt};
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model, and
   // leave the caller 1 time unit after the edge to sample.
   task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      model_edge(iv, d, c, ordy, fl);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (act_vec() !== {1'b0, 1'b1, 32'd0, 11'd0, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", act_vec(), {1'b0, 1'b1, 32'd0, 11'd0, 4'd0, 4'd0});
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, DW'(i), CW'($urandom), 1'b1, 1'b0);
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stream_model beat=%0d got=%h exp=%h", i, act_vec(), exp_vec());
         end
         checks++;
         if (out_valid !== 1'b1 || out_data !== DW'(i) || in_ready !== 1'b1 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL stream_beat beat=%0d got v=%b d=%h rdy=%b st=%0d exp v=1 d=%h rdy=1 st=0",
                     i, out_valid, out_data, in_ready, stall_cnt, DW'(i));
         end
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL stream_drain got=%h exp=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(1'b1, 32'hA, 11'h011, 1'b0, 1'b0);
      step(1'b1, 32'hB, 11'h022, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0);
         checks++;
         if (in_ready !== 1'b0 || out_data !== 32'hA || stall_cnt !== NW'(i + 2)) begin
            errors++;
            $display("FAIL bp_full cyc=%0d got rdy=%b d=%h st=%0d exp rdy=0 d=a st=%0d",
                     i, in_ready, out_data, stall_cnt, i + 2);
         end
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hB || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL bp_second got=%h exp=%h", act_vec(), exp_vec());
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0) begin
         errors++;
         $display("FAIL bp_empty got v=%b rdy=%b c=%h exp v=0 rdy=1 c=0", out_valid, in_ready, out_ctrl);
      end
   endtask

   task automatic test_flush_full();
      do_reset();
      step(1'b1, 32'h100, 11'h155, 1'b0, 1'b0);
      step(1'b1, 32'h200, 11'h2AA, 1'b0, 1'b0);
      step(1'b1, 32'h300, 11'h7FF, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || drop_cnt !== NW'(2)) begin
         errors++;
         $display("FAIL flush_full got v=%b c=%h rdy=%b drop=%0d exp v=0 c=0 rdy=1 drop=2",
                  out_valid, out_ctrl, in_ready, drop_cnt);
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL flush_full_model got=%h exp=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_flush_fire();
      do_reset();
      // held beat leaves in the flush cycle, incoming beat is dropped
      step(1'b1, 32'h77, 11'h044, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h77) begin
         errors++;
         $display("FAIL flushfire_pre got v=%b d=%h exp v=1 d=77", out_valid, out_data);
      end
      step(1'b1, 32'h88, 11'h0FF, 1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || drop_cnt !== NW'(1) || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flushfire_in got v=%b drop=%0d rdy=%b exp v=0 drop=1 rdy=1", out_valid, drop_cnt, in_ready);
      end
      // same again with no incoming beat: nothing dropped
      step(1'b1, 32'h99, 11'h001, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || drop_cnt !== NW'(1) || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL flushfire_noin got=%h exp=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_stall_sat();
      do_reset();
      step(1'b1, 32'h5, 11'h3, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt !== NW'(MAXC) || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL stall_sat got st=%0d exp st=%0d", stall_cnt, MAXC);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, 32'hDEAD, 11'h7FF, 1'b0, 1'b0);
      step(1'b1, 32'hBEEF, 11'h7FF, 1'b0, 1'b0);
      #3 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (act_vec() !== {1'b0, 1'b1, 32'd0, 11'd0, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", act_vec(), {1'b0, 1'b1, 32'd0, 11'd0, 4'd0, 4'd0});
      end
      #1 rst = 1'b1;
      step(1'b1, 32'h55, 11'h012, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h55 || out_ctrl !== 11'h012) begin
         errors++;
         $display("FAIL async_first got v=%b d=%h c=%h exp v=1 d=55 c=012", out_valid, out_data, out_ctrl);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL async_nostale got=%h exp=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(logic'($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
              logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 24) == 0));
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            bad++;
            if (bad <= 10) $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_full();
      test_flush_fire();
      test_stall_sat();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
